// File: rtl/packetizer_4_serial.sv
// Serializes one payload word plus destination and VC into a 4-flit NoC packet
// (head, body1, body2, tail), emitting one flit per cycle with valid/ready flow control.
`timescale 1ns/1ps
module packetizer_4_serial #(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 12,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_DATA-1:0]       i_data_in,
  input  logic [ADDRESS_WIDTH-1:0]    i_dest_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] i_vc_in,
  input  logic                        i_valid_in,
  output logic                        i_ready_out,
  output logic [WIDTH_PKT/4-1:0]      o_flit_out,
  output logic                        o_valid_out,
  input  logic                        o_ready_in
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Upstream payload: i_valid_in/i_ready_out. Downstream flit: o_valid_out/o_ready_in.
  // Once valid is raised, the flit and its state are held until ready is seen.

  localparam int WIDTH_FLIT     = WIDTH_PKT / 4;
  localparam int WIDTH_DATA_IDL = WIDTH_PKT - 12 - 4 * VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int PAD_BITS       = WIDTH_DATA_IDL - WIDTH_DATA;
  localparam int HEAD_BITS      = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int BODY_BITS      = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
  localparam int BODY1_MSB      = WIDTH_DATA_IDL - 1 - HEAD_BITS;
  localparam int BODY2_MSB      = BODY1_MSB - BODY_BITS;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD  = 3'd1,
    S_BODY1 = 3'd2,
    S_BODY2 = 3'd3,
    S_TAIL  = 3'd4
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [WIDTH_DATA_IDL-1:0]     data_q;
  logic [ADDRESS_WIDTH-1:0]      dest_q;
  logic [VC_ADDRESS_WIDTH-1:0]   vc_q;
  logic                          accept;

  // Ready only depends on o_ready_in in TAIL, so the next head follows the tail with no bubble.
  always_comb begin
    i_ready_out = (state == S_IDLE) || ((state == S_TAIL) && o_ready_in);
    accept      = i_valid_in && i_ready_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      data_q <= '0;
      dest_q <= '0;
      vc_q   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        data_q <= WIDTH_DATA_IDL'(i_data_in) << PAD_BITS;
        dest_q <= i_dest_in;
        vc_q   <= i_vc_in;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept)     state_next = S_HEAD;
      S_HEAD:  if (o_ready_in) state_next = S_BODY1;
      S_BODY1: if (o_ready_in) state_next = S_BODY2;
      S_BODY2: if (o_ready_in) state_next = S_TAIL;
      S_TAIL:  if (o_ready_in) state_next = accept ? S_HEAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Flit layout MSB first: valid, head, tail, vc, [dest on head only], data slice.
  always_comb begin
    o_valid_out = (state != S_IDLE);
    o_flit_out  = '0;
    case (state)
      S_HEAD:  o_flit_out = {3'b110, vc_q, dest_q, data_q[WIDTH_DATA_IDL-1 -: HEAD_BITS]};
      S_BODY1: o_flit_out = {3'b100, vc_q, data_q[BODY1_MSB -: BODY_BITS]};
      S_BODY2: o_flit_out = {3'b100, vc_q, data_q[BODY2_MSB -: BODY_BITS]};
      S_TAIL:  o_flit_out = {3'b101, vc_q, data_q[BODY_BITS-1:0]};
      default: o_flit_out = '0;
    endcase
  end
endmodule

// File: tb/tb_packetizer_4_serial.sv
// Scoreboard bench for packetizer_4_serial at default parameters (9-bit flits):
// directed packets, backpressure, back-to-back, mid-packet reset, then randomized traffic.
`timescale 1ns/1ps
module tb_packetizer_4_serial;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] i_data_in;
  logic [3:0]  i_dest_in;
  logic [0:0]  i_vc_in;
  logic        i_valid_in;
  logic        i_ready_out;
  logic [8:0]  o_flit_out;
  logic        o_valid_out;
  logic        o_ready_in;

  logic        rand_bp;
  logic        ready_force;
  int          n_vec = 0;
  int          n_err = 0;

  logic [8:0]  exp_q[$];
  logic [11:0] dat_q[$];
  logic [15:0] asm_bits;
  int          asm_cnt;
  logic        stall_prev;
  logic [8:0]  prev_flit;
  logic        head_due;

  packetizer_4_serial dut (
    .clk         (clk),
    .rst         (rst),
    .i_data_in   (i_data_in),
    .i_dest_in   (i_dest_in),
    .i_vc_in     (i_vc_in),
    .i_valid_in  (i_valid_in),
    .i_ready_out (i_ready_out),
    .o_flit_out  (o_flit_out),
    .o_valid_out (o_valid_out),
    .o_ready_in  (o_ready_in)
  );

  // Clock and downstream ready generation
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    o_ready_in = rand_bp ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Reference model: 16-bit payload field is the data word followed by 4 zero bits,
  // handed out 1 bit to the head and 5 bits to each of body1, body2, tail.
  function automatic logic [8:0] model_flit(int idx, logic [11:0] d, logic [3:0] dst, logic v);
    int full;
    int f;
    full = int'(d) * 16;
    case (idx)
      0:       f = 'h180 + int'(v) * 32 + int'(dst) * 2 + (full / 32768) % 2;
      1:       f = 'h100 + int'(v) * 32 + (full / 1024) % 32;
      2:       f = 'h100 + int'(v) * 32 + (full / 32) % 32;
      default: f = 'h140 + int'(v) * 32 + full % 32;
    endcase
    return f[8:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      dat_q.delete();
      asm_cnt    = 0;
      asm_bits   = '0;
      stall_prev = 1'b0;
      head_due   = 1'b0;
    end else begin
      chk("ready", {31'b0, i_ready_out},
          {31'b0, (exp_q.size() == 0) || (exp_q.size() == 1 && o_ready_in)});
      chk("valid", {31'b0, o_valid_out}, {31'b0, exp_q.size() != 0});
      if (head_due) chk("head_latency", {30'b0, o_valid_out, o_flit_out[7]}, 32'd3);
      if (stall_prev) chk("hold", {22'b0, o_valid_out, o_flit_out}, {22'b0, 1'b1, prev_flit});
      if (!o_valid_out) begin
        chk("idle_flit", {23'b0, o_flit_out}, 32'd0);
      end else if (exp_q.size() != 0 && o_ready_in) begin
        chk("flit", {23'b0, o_flit_out}, {23'b0, exp_q.pop_front()});
        if (asm_cnt == 0) asm_bits = {15'b0, o_flit_out[0]};
        else              asm_bits = {asm_bits[10:0], o_flit_out[4:0]};
        asm_cnt++;
        if (asm_cnt == 4) begin
          asm_cnt = 0;
          if (dat_q.size() != 0) chk("data", {20'b0, asm_bits[15:4]}, {20'b0, dat_q.pop_front()});
        end
      end
      stall_prev = o_valid_out && !o_ready_in;
      prev_flit  = o_flit_out;
      head_due   = 1'b0;
      if (i_valid_in && i_ready_out) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(model_flit(k, i_data_in, i_dest_in, i_vc_in[0]));
        dat_q.push_back(i_data_in);
        head_due = 1'b1;
      end
    end
  end

  // Driver tasks (inputs change 1 ns after the rising edge)
  task automatic send(input logic [11:0] d, input logic [3:0] dst, input logic v);
    logic done;
    done       = 1'b0;
    i_data_in  = d;
    i_dest_in  = dst;
    i_vc_in    = v;
    i_valid_in = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = i_ready_out;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    i_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    i_valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_data_in   = '0;
    i_dest_in   = '0;
    i_vc_in     = '0;
    i_valid_in  = 1'b0;
    rand_bp     = 1'b0;
    ready_force = 1'b1;
    o_ready_in  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Single packet: 18B, 10A, 11E, 140
    send(12'hABC, 4'h5, 1'b0);
    idle(6);

    // Hold ready low for 3 cycles while body1 is presented
    send(12'hABC, 4'h5, 1'b0);
    @(posedge clk);
    #1 ready_force = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    idle(6);

    // vc=1, dest=F, data=0: head 1BE, bodies 120, tail 160
    send(12'h000, 4'hF, 1'b1);
    idle(6);

    // Back-to-back payloads
    send(12'h123, 4'h3, 1'b0);
    send(12'h456, 4'hA, 1'b1);
    idle(10);

    // Reset while body1 is on the output: packet is dropped
    send(12'hABC, 4'h5, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(6);

    // Random traffic with random backpressure
    rand_bp = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send(12'($urandom), 4'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    for (int t = 0; t < 300 && (exp_q.size() != 0 || o_valid_out); t++) @(posedge clk);
    chk("drain", exp_q.size(), 32'd0);
    rand_bp = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
